// File: rtl/pmem_loader_pkg.sv
// Shared definitions for the boot-time program-memory loader and the writable
// program memory it feeds.
package pmem_loader_pkg;

    localparam int         ADDR_W_DEF = 10;
    localparam int         DEPTH_DEF  = 256;
    localparam logic [7:0] MAGIC_DEF  = 8'hA5;

    // Frame header carries a 16-bit little-endian word count.
    localparam int COUNT_W    = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
interface pmem_loader_if
    import pmem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              byte_valid_c0;
    logic [7:0]        byte_c0;
    logic              pmem_we_c1;
    logic [ADDR_W-1:0] pmem_addr_c1;
    logic [31:0]       pmem_wdata_c1;

    // master: the loader; slave: byte source and program memory side.
    modport master (
        input  byte_valid_c0, byte_c0,
        output pmem_we_c1, pmem_addr_c1, pmem_wdata_c1
    );

    modport slave (
        output byte_valid_c0, byte_c0,
        input  pmem_we_c1, pmem_addr_c1, pmem_wdata_c1
    );

endinterface

// File: rtl/pmem_loader.sv
// Parses a framed byte stream, packs little-endian 32-bit words into program
// memory and releases the core only after the frame checksum verifies.
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         DEPTH  = DEPTH_DEF,
    parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pmem_loader_if.master bus,
    output logic          cpu_run,
    output logic          load_busy,
    output logic          load_err
);

    state_t             state_q, state_d;
    logic [7:0]         cnt_lo_q;
    logic [COUNT_W-1:0] words_left_q;
    logic [1:0]         byte_idx_q;
    logic [23:0]        word_q;
    logic [7:0]         csum_q;
    logic [ADDR_W-1:0]  waddr_q;

    logic               take;
    logic               is_magic;
    logic               last_byte;
    logic [COUNT_W-1:0] count;

    assign take      = bus.byte_valid_c0;
    assign is_magic  = (bus.byte_c0 == MAGIC);
    assign last_byte = (byte_idx_q == 2'd3);
    assign count     = {bus.byte_c0, cnt_lo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (take) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (is_magic) state_d = S_CNT_LO;
                S_CNT_LO:              state_d = S_CNT_HI;
                S_CNT_HI: begin
                    if (int'(count) > DEPTH)     state_d = S_ERR;
                    else if (count == '0)        state_d = S_CSUM;
                    else                         state_d = S_DATA;
                end
                S_DATA: begin
                    if (last_byte && words_left_q == COUNT_W'(1)) state_d = S_CSUM;
                end
                S_CSUM:  state_d = (bus.byte_c0 == csum_q) ? S_DONE : S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status is decoded straight from the registered state, so it moves the
    // cycle after the byte that caused the transition.
    assign load_busy = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
    assign cpu_run   = (state_q == S_DONE);
    assign load_err  = (state_q == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lo_q          <= '0;
            words_left_q      <= '0;
            byte_idx_q        <= '0;
            word_q            <= '0;
            csum_q            <= '0;
            waddr_q           <= '0;
            bus.pmem_we_c1    <= 1'b0;
            bus.pmem_addr_c1  <= '0;
            bus.pmem_wdata_c1 <= '0;
        end else begin
            bus.pmem_we_c1 <= 1'b0;
            if (take) begin
                case (state_q)
                    S_CNT_LO: cnt_lo_q <= bus.byte_c0;
                    S_CNT_HI: begin
                        words_left_q <= count;
                        waddr_q      <= '0;
                        byte_idx_q   <= '0;
                        csum_q       <= '0;
                    end
                    S_DATA: begin
                        csum_q     <= csum_q + bus.byte_c0;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= bus.byte_c0;
                            2'd1: word_q[15:8]  <= bus.byte_c0;
                            2'd2: word_q[23:16] <= bus.byte_c0;
                            default: begin
                                // Fourth byte completes the word; address/data hold after the pulse.
                                bus.pmem_we_c1    <= 1'b1;
                                bus.pmem_addr_c1  <= waddr_q;
                                bus.pmem_wdata_c1 <= {bus.byte_c0, word_q};
                                waddr_q           <= waddr_q + ADDR_W'(WORD_BYTES);
                                words_left_q      <= words_left_q - COUNT_W'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader: directed vectors, corner sequences and
// randomized frames compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_pmem_loader;

    localparam int         ADDR_W = 10;
    localparam int         DEPTH  = 256;
    localparam logic [7:0] MAGIC  = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_run, load_busy, load_err;

    pmem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    pmem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_run   (cpu_run),
        .load_busy (load_busy),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [15:0] cnt;
        int          junk;
        logic [7:0]  delta;
        int          max_gap;
        logic        exp_run;
        logic        exp_err;
        int          exp_writes;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] byte_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_we_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Write-port monitor: record every pulse and reject back-to-back pulses.
    always @(negedge clk) begin
        cyc++;
        if (bus.pmem_we_c1 === 1'b1) begin
            check("we_not_back_to_back", 32'(cyc - last_we_cyc >= 2), 32'd1);
            got_q.push_back('{32'(bus.pmem_addr_c1), bus.pmem_wdata_c1, cyc});
            last_we_cyc = cyc;
        end
    end

    // Reference model: frame bytes plus the word writes they must produce.
    task automatic build_frame(input logic [15:0] cnt, input int junk, input logic [7:0] delta);
        logic [7:0]  sum;
        logic [31:0] w;
        byte_q.delete();
        exp_q.delete();
        for (int j = 0; j < junk; j++) byte_q.push_back((j % 2 == 1) ? 8'hFF : 8'h00);
        byte_q.push_back(MAGIC);
        byte_q.push_back(cnt[7:0]);
        byte_q.push_back(cnt[15:8]);
        if (int'(cnt) > DEPTH) return;
        sum = 8'h00;
        for (int i = 0; i < int'(cnt); i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                byte_q.push_back(w[8*k +: 8]);
                sum = sum + w[8*k +: 8];
            end
            exp_q.push_back('{32'(i * 4), w, 0});
        end
        byte_q.push_back(sum + delta);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.byte_valid_c0 = 1'b1;
        bus.byte_c0       = b;
        @(negedge clk);
        bus.byte_valid_c0 = 1'b0;
    endtask

    task automatic send_q(input int max_gap);
        foreach (byte_q[i]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            drive_byte(byte_q[i]);
        end
    endtask

    // Status right after the final byte, then the complete write log.
    task automatic verify(input string tag, input logic er, input logic ee, input int nw,
                          input bit full_rate);
        int n;
        check({tag, "_cpu_run"},   32'(cpu_run),   32'(er));
        check({tag, "_load_err"},  32'(load_err),  32'(ee));
        check({tag, "_load_busy"}, 32'(load_busy), 32'd0);
        @(negedge clk);
        check({tag, "_num_writes"}, 32'(got_q.size()), 32'(nw));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
            if (full_rate && i > 0)
                check({tag, "_spacing"}, 32'(got_q[i].cyc - got_q[i-1].cyc), 32'd4);
        end
        got_q.delete();
    endtask

    task automatic spec_frame(input logic [7:0] csum);
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h00, 8'h00, csum};
        exp_q.delete();
        exp_q.push_back('{32'h0, 32'h0000_0113, 0});
        exp_q.push_back('{32'h4, 32'h0000_0093, 0});
    endtask

    vec_t vecs[9];

    initial begin
        logic [15:0] rcnt;
        logic [7:0]  rdelta;
        logic        rrun;

        bus.byte_valid_c0 = 1'b0;
        bus.byte_c0       = 8'h00;

        vecs = '{
            '{16'd2,     0, 8'h00, 2, 1'b1, 1'b0, 2},
            '{16'd2,     0, 8'hFF, 0, 1'b0, 1'b1, 2},
            '{16'd257,   0, 8'h00, 0, 1'b0, 1'b1, 0},
            '{16'd0,     2, 8'h00, 0, 1'b1, 1'b0, 0},
            '{16'd256,   0, 8'h00, 0, 1'b1, 1'b0, 256},
            '{16'd1,     1, 8'h01, 3, 1'b0, 1'b1, 1},
            '{16'd512,   0, 8'h00, 0, 1'b0, 1'b1, 0},
            '{16'hFFFF,  0, 8'h00, 0, 1'b0, 1'b1, 0},
            '{16'd3,     3, 8'h00, 1, 1'b1, 1'b0, 3}
        };

        repeat (3) @(negedge clk);
        check("rst_we",    32'(bus.pmem_we_c1),   32'd0);
        check("rst_addr",  32'(bus.pmem_addr_c1), 32'd0);
        check("rst_wdata", bus.pmem_wdata_c1,     32'd0);
        check("rst_run",   32'(cpu_run),          32'd0);
        check("rst_busy",  32'(load_busy),        32'd0);
        check("rst_err",   32'(load_err),         32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-good frame; busy must rise the cycle after MAGIC.
        spec_frame(8'hA7);
        drive_byte(byte_q.pop_front());
        check("magic_busy", 32'(load_busy), 32'd1);
        send_q(0);
        verify("spec_ok", 1'b1, 1'b0, 2, 1'b0);

        // Restart from DONE drops cpu_run at once; bad checksum still writes.
        spec_frame(8'hA6);
        drive_byte(byte_q.pop_front());
        check("restart_run_drop", 32'(cpu_run),   32'd0);
        check("restart_busy",     32'(load_busy), 32'd1);
        send_q(0);
        verify("spec_bad_csum", 1'b0, 1'b1, 2, 1'b0);

        foreach (vecs[v]) begin
            build_frame(vecs[v].cnt, vecs[v].junk, vecs[v].delta);
            send_q(vecs[v].max_gap);
            verify($sformatf("vec%0d", v), vecs[v].exp_run, vecs[v].exp_err,
                   vecs[v].exp_writes, vecs[v].max_gap == 0);
        end

        // Reset in the middle of a word: no pulse, everything back to reset values.
        byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01};
        send_q(0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(load_busy),        32'd0);
        check("midrst_addr", 32'(bus.pmem_addr_c1), 32'd0);
        repeat (4) @(negedge clk);
        check("midrst_no_write", 32'(got_q.size()),     32'd0);
        check("midrst_we",       32'(bus.pmem_we_c1),   32'd0);
        check("midrst_wdata",    bus.pmem_wdata_c1,     32'd0);
        check("midrst_run",      32'(cpu_run),          32'd0);
        check("midrst_err",      32'(load_err),         32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        spec_frame(8'hA7);
        send_q(0);
        verify("after_rst", 1'b1, 1'b0, 2, 1'b0);

        // Randomized frames against the model.
        for (int r = 0; r < 40; r++) begin
            rcnt   = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) rcnt = 16'(DEPTH + $urandom_range(1, 300));
            rdelta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            rrun   = (int'(rcnt) <= DEPTH) && (rdelta == 8'h00);
            build_frame(rcnt, $urandom_range(0, 3), rdelta);
            send_q($urandom_range(0, 2));
            verify($sformatf("rand%0d", r), rrun, !rrun, exp_q.size(), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
